// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared framing constants and FSM state encodings for the UART.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_tick_gen
// Brief    : Free-running divider emitting one oversample tick every DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_q == c_last) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_transceiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_transceiver
// Brief    : Full-duplex 8N1 UART byte transceiver, 16x oversampled receiver.
// Revision : 1.0 - initial release
// ============================================================================
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int baud_rate    = 9600,
    parameter int sys_clk_freq = 12000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       is_transmitting,
    output logic       recv_error
);

    localparam int DIV_RAW = sys_clk_freq / (baud_rate * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

    localparam logic [3:0] c_phase_last = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] c_phase_mid  = 4'(MID_SAMPLE - 1);
    localparam logic [2:0] c_bit_last   = 3'(DATA_BITS - 1);

    logic       tick;
    logic       rx_meta_q, rx_sync_q;

    rx_state_t  rx_state_q;
    logic [3:0] rx_phase_q;
    logic [2:0] rx_bit_q;
    logic [7:0] rx_shift_q, rx_byte_q;
    logic       received_q, recv_error_q, is_receiving_q;

    tx_state_t  tx_state_q;
    logic [3:0] tx_phase_q;
    logic [2:0] tx_bit_q;
    logic [7:0] tx_shift_q;
    logic       tx_q, is_transmitting_q;

    uart_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver: phase counts ticks within the current bit; data bits are sampled mid-bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q     <= RX_IDLE;
            rx_phase_q     <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_byte_q      <= '0;
            received_q     <= 1'b0;
            recv_error_q   <= 1'b0;
            is_receiving_q <= 1'b0;
        end else begin
            received_q   <= 1'b0;
            recv_error_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_state_q     <= RX_START;
                        rx_phase_q     <= '0;
                        is_receiving_q <= 1'b1;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_phase_q == c_phase_mid) begin
                            rx_phase_q <= '0;
                            rx_bit_q   <= '0;
                            if (rx_sync_q) begin
                                rx_state_q     <= RX_IDLE;
                                is_receiving_q <= 1'b0;
                            end else begin
                                rx_state_q <= RX_DATA;
                            end
                        end else begin
                            rx_phase_q <= rx_phase_q + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_phase_q == c_phase_last) begin
                            rx_phase_q <= '0;
                            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                            if (rx_bit_q == c_bit_last) begin
                                rx_state_q <= RX_STOP;
                            end else begin
                                rx_bit_q <= rx_bit_q + 3'd1;
                            end
                        end else begin
                            rx_phase_q <= rx_phase_q + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rx_phase_q == c_phase_last) begin
                            rx_phase_q <= '0;
                            if (rx_sync_q) begin
                                rx_byte_q      <= rx_shift_q;
                                received_q     <= 1'b1;
                                is_receiving_q <= 1'b0;
                                rx_state_q     <= RX_IDLE;
                            end else begin
                                recv_error_q <= 1'b1;
                                rx_state_q   <= RX_WAIT_IDLE;
                            end
                        end else begin
                            rx_phase_q <= rx_phase_q + 4'd1;
                        end
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rx_sync_q) begin
                        rx_state_q     <= RX_IDLE;
                        is_receiving_q <= 1'b0;
                    end
                end
                default: begin
                    rx_state_q     <= RX_IDLE;
                    is_receiving_q <= 1'b0;
                end
            endcase
        end
    end

    // Transmitter: tx is registered so reset forces the line high without a glitch path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q        <= TX_IDLE;
            tx_phase_q        <= '0;
            tx_bit_q          <= '0;
            tx_shift_q        <= '0;
            tx_q              <= 1'b1;
            is_transmitting_q <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (transmit) begin
                        tx_shift_q        <= tx_byte;
                        tx_phase_q        <= '0;
                        tx_q              <= 1'b0;
                        is_transmitting_q <= 1'b1;
                        tx_state_q        <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (tx_phase_q == c_phase_last) begin
                            tx_phase_q <= '0;
                            tx_bit_q   <= '0;
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_state_q <= TX_DATA;
                        end else begin
                            tx_phase_q <= tx_phase_q + 4'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_phase_q == c_phase_last) begin
                            tx_phase_q <= '0;
                            if (tx_bit_q == c_bit_last) begin
                                tx_q       <= 1'b1;
                                tx_state_q <= TX_STOP;
                            end else begin
                                tx_bit_q   <= tx_bit_q + 3'd1;
                                tx_q       <= tx_shift_q[0];
                                tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            end
                        end else begin
                            tx_phase_q <= tx_phase_q + 4'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (tx_phase_q == c_phase_last) begin
                            tx_phase_q        <= '0;
                            is_transmitting_q <= 1'b0;
                            tx_state_q        <= TX_IDLE;
                        end else begin
                            tx_phase_q <= tx_phase_q + 4'd1;
                        end
                    end
                end
                default: begin
                    tx_q              <= 1'b1;
                    is_transmitting_q <= 1'b0;
                    tx_state_q        <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx              = tx_q;
    assign received        = received_q;
    assign rx_byte         = rx_byte_q;
    assign is_receiving    = is_receiving_q;
    assign is_transmitting = is_transmitting_q;
    assign recv_error      = recv_error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_transceiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_transceiver
// Brief    : Self-checking bench for uart_transceiver (DIV=1, 16 clk per bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transceiver;

    localparam int SYS_CLK  = 1600000;
    localparam int BAUD     = 100000;
    localparam int BIT_CLKS = 16;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_drv   = 1'b1;
    logic       loop_en  = 1'b0;
    logic       transmit = 1'b0;
    logic [7:0] tx_byte  = 8'h00;
    logic       w_rx;
    logic       tx, received, is_receiving, is_transmitting, recv_error;
    logic [7:0] rx_byte;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] rx_seen[$];
    int         err_seen = 0;
    logic [7:0] last_good = 8'h00;

    assign w_rx = loop_en ? tx : rx_drv;

    uart_transceiver #(
        .baud_rate    (BAUD),
        .sys_clk_freq (SYS_CLK)
    ) dut (
        .clk             (clk),
        .rst             (rst_n),
        .rx              (w_rx),
        .tx              (tx),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .received        (received),
        .rx_byte         (rx_byte),
        .is_receiving    (is_receiving),
        .is_transmitting (is_transmitting),
        .recv_error      (recv_error)
    );

    always #5 clk = ~clk;

    // Every received/recv_error pulse is logged once per clk it is high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (received)   rx_seen.push_back(rx_byte);
            if (recv_error) err_seen++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = frame[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({tx, received, rx_byte, is_receiving, is_transmitting, recv_error} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: tx=%b rcv=%b rx_byte=%h is_rx=%b is_tx=%b err=%b, want 1 0 00 0 0 0",
                     tx, received, rx_byte, is_receiving, is_transmitting, recv_error);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (tx !== 1'b1 || is_transmitting !== 1'b0 || is_receiving !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: tx=%b is_tx=%b is_rx=%b, want 1 0 0", tx, is_transmitting, is_receiving);
        end
    endtask

    // Expected line: start(0), 8 data bits LSB first, stop(1), each 16 clk.
    task automatic test_tx_frame(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        @(negedge clk);
        transmit = 1'b1;
        tx_byte  = b;
        @(negedge clk);
        transmit = 1'b0;
        tx_byte  = 8'($urandom());
        for (int k = 0; k < 10 * BIT_CLKS; k++) begin
            tests++;
            if (tx !== frame[k / BIT_CLKS] || is_transmitting !== 1'b1) begin
                fails++;
                $display("FAIL tx_%h bit%0d clk%0d: tx=%b is_tx=%b, want tx=%b is_tx=1",
                         b, k / BIT_CLKS, k, tx, is_transmitting, frame[k / BIT_CLKS]);
            end
            @(negedge clk);
        end
        tests++;
        if (tx !== 1'b1 || is_transmitting !== 1'b0) begin
            fails++;
            $display("FAIL tx_%h_end: tx=%b is_tx=%b, want tx=1 is_tx=0", b, tx, is_transmitting);
        end
    endtask

    task automatic test_rx(input logic [7:0] b);
        rx_seen.delete();
        err_seen = 0;
        drive_rx_frame(b, 1'b1);
        repeat (20) @(negedge clk);
        tests++;
        if (rx_seen.size() !== 1) begin
            fails++;
            $display("FAIL rx_%h_count: got %0d received pulses, want 1", b, rx_seen.size());
        end else begin
            tests++;
            if (rx_seen[0] !== b) begin
                fails++;
                $display("FAIL rx_%h_data: got %h, want %h", b, rx_seen[0], b);
            end
        end
        tests++;
        if (rx_byte !== b || err_seen !== 0 || is_receiving !== 1'b0) begin
            fails++;
            $display("FAIL rx_%h_after: rx_byte=%h errs=%0d is_rx=%b, want %h 0 0",
                     b, rx_byte, err_seen, is_receiving, b);
        end
        last_good = b;
    endtask

    task automatic test_frame_error(input logic [7:0] b);
        logic [7:0] prev;
        prev = last_good;
        rx_seen.delete();
        err_seen = 0;
        drive_rx_frame(b, 1'b0);
        repeat (20) @(negedge clk);
        tests++;
        if (err_seen !== 1 || rx_seen.size() !== 0) begin
            fails++;
            $display("FAIL frame_error: got %0d errors %0d receives, want 1 error 0 receives",
                     err_seen, rx_seen.size());
        end
        tests++;
        if (rx_byte !== prev || is_receiving !== 1'b0) begin
            fails++;
            $display("FAIL frame_error_hold: rx_byte=%h is_rx=%b, want %h 0", rx_byte, is_receiving, prev);
        end
        test_rx(8'h55);
    endtask

    task automatic test_glitch();
        rx_seen.delete();
        err_seen = 0;
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        tests++;
        if (is_receiving !== 1'b1) begin
            fails++;
            $display("FAIL glitch_start: is_rx=%b, want 1", is_receiving);
        end
        for (int k = 0; k < 9 && is_receiving !== 1'b0; k++) @(negedge clk);
        tests++;
        if (is_receiving !== 1'b0) begin
            fails++;
            $display("FAIL glitch_recover: is_rx=%b after 9 clk, want 0", is_receiving);
        end
        repeat (200) @(negedge clk);
        tests++;
        if (rx_seen.size() !== 0 || err_seen !== 0) begin
            fails++;
            $display("FAIL glitch_pulses: got %0d receives %0d errors, want 0 0", rx_seen.size(), err_seen);
        end
    endtask

    task automatic test_loopback(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] exp_q[$];
        exp_q = '{b0, b1, b2};
        loop_en = 1'b1;
        rx_seen.delete();
        err_seen = 0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            transmit = 1'b1;
            tx_byte  = exp_q[i];
            @(negedge clk);
            transmit = 1'b0;
            if (i == 0) begin
                repeat (70) @(negedge clk);
                transmit = 1'b1;
                tx_byte  = ~b0;
                @(negedge clk);
                transmit = 1'b0;
            end
            for (int k = 0; k < 400 && is_transmitting !== 1'b0; k++) @(negedge clk);
            tests++;
            if (is_transmitting !== 1'b0) begin
                fails++;
                $display("FAIL loop_tx_done%0d: is_tx=%b after 400 clk, want 0", i, is_transmitting);
            end
        end
        repeat (40) @(negedge clk);
        tests++;
        if (rx_seen.size() !== 3 || err_seen !== 0) begin
            fails++;
            $display("FAIL loop_count: got %0d frames %0d errors, want 3 0", rx_seen.size(), err_seen);
        end
        for (int i = 0; i < 3 && i < rx_seen.size(); i++) begin
            tests++;
            if (rx_seen[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL loop_data%0d: got %h, want %h", i, rx_seen[i], exp_q[i]);
            end
        end
        loop_en = 1'b0;
        last_good = b2;
    endtask

    task automatic test_reset_mid_tx();
        @(negedge clk);
        transmit = 1'b1;
        tx_byte  = 8'h00;
        @(negedge clk);
        transmit = 1'b0;
        repeat (50) @(negedge clk);
        tests++;
        if (tx !== 1'b0 || is_transmitting !== 1'b1) begin
            fails++;
            $display("FAIL midtx_pre: tx=%b is_tx=%b, want 0 1", tx, is_transmitting);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (tx !== 1'b1 || is_transmitting !== 1'b0) begin
            fails++;
            $display("FAIL midtx_async_reset: tx=%b is_tx=%b, want 1 0", tx, is_transmitting);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_tx_frame(8'h12);
    endtask

    initial begin
        test_reset();
        test_tx_frame(8'hA5);
        test_tx_frame(8'($urandom()));
        test_rx(8'h3C);
        for (int i = 0; i < 3; i++) test_rx(8'($urandom()));
        test_frame_error(8'($urandom()));
        test_glitch();
        test_loopback(8'h00, 8'hFF, 8'h81);
        test_loopback(8'($urandom()), 8'($urandom()), 8'($urandom()));
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
